// File: rtl/ofs_plat_avalon_mem_rsp_ram.sv
// ofs_plat_avalon_mem_rsp_ram
// Avalon-MM responder backed by a 2^DEPTH_LOG2-word RAM. Write bursts stream
// in with no stall; read bursts return one beat per cycle while the request
// port is held off. Storage is never cleared by reset.
// Optional feature: define OFS_PLAT_AVALON_MEM_RSP_RAM_WRRSP_EN to generate a
// one-cycle write response after the last beat of each write burst.
module ofs_plat_avalon_mem_rsp_ram #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int BURST_CNT_WIDTH = 4,
    parameter int USER_WIDTH      = 1,
    parameter int DEPTH_LOG2      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_WIDTH-1:0]      address,
    input  logic                       read,
    input  logic                       write,
    input  logic [BURST_CNT_WIDTH-1:0] burstcount,
    input  logic [DATA_WIDTH-1:0]      writedata,
    input  logic [DATA_WIDTH/8-1:0]    byteenable,
    input  logic [USER_WIDTH-1:0]      user,
    output logic                       waitrequest,
    output logic                       readdatavalid,
    output logic [DATA_WIDTH-1:0]      readdata,
    output logic [1:0]                 response,
    output logic [USER_WIDTH-1:0]      readresponseuser,
    output logic                       writeresponsevalid,
    output logic [1:0]                 writeresponse,
    output logic [USER_WIDTH-1:0]      writeresponseuser
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR_BURST = 2'd1;
    localparam logic [1:0] RD_BURST = 2'd2;

    localparam logic [DEPTH_LOG2-1:0]      ADDR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [BURST_CNT_WIDTH-1:0] CNT_ZERO = {BURST_CNT_WIDTH{1'b0}};
    localparam logic [BURST_CNT_WIDTH-1:0] CNT_ONE  = {{(BURST_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0]      mem [DEPTH];

    logic [1:0]                 state_r;
    logic                       wait_r;
    logic [DEPTH_LOG2-1:0]      rd_addr_r;
    logic [BURST_CNT_WIDTH-1:0] rd_left_r;
    logic [DEPTH_LOG2-1:0]      wr_addr_r;
    logic [BURST_CNT_WIDTH-1:0] wr_left_r;

    logic                       sop_ok_s;
    logic                       wr_sop_s;
    logic                       rd_sop_s;
    logic                       wr_beat_s;
    logic                       wr_en_s;
    logic                       wr_last_s;
    logic [DEPTH_LOG2-1:0]      base_s;
    logic [DEPTH_LOG2-1:0]      wr_idx_s;
    logic [BURST_CNT_WIDTH-1:0] cnt_s;
    logic                       unused_addr_s;

    // Upper address bits are outside the storage window and intentionally dropped.
    assign unused_addr_s = &{1'b0, address[ADDR_WIDTH-1:DEPTH_LOG2]};

    assign waitrequest = wait_r;
    assign base_s      = address[DEPTH_LOG2-1:0];

    // Request decode: start-of-packet only in IDLE with the port open; write wins over read.
    always_comb begin
        sop_ok_s  = (state_r == IDLE) && !wait_r;
        wr_sop_s  = sop_ok_s && write;
        rd_sop_s  = sop_ok_s && read && !write;
        wr_beat_s = (state_r == WR_BURST) && write;
        wr_en_s   = wr_sop_s || wr_beat_s;
        if (burstcount == CNT_ZERO) begin
            cnt_s = CNT_ONE;
        end else begin
            cnt_s = burstcount;
        end
        if (wr_sop_s) begin
            wr_idx_s  = base_s;
            wr_last_s = (cnt_s == CNT_ONE);
        end else begin
            wr_idx_s  = wr_addr_r;
            wr_last_s = wr_beat_s && (wr_left_r == CNT_ONE);
        end
    end

    // Byte-lane gated storage write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byteenable[b]) begin
                    mem[wr_idx_s][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
    end

    // Burst FSM, stall control and registered read-beat generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= IDLE;
            wait_r           <= 1'b1;
            readdatavalid    <= 1'b0;
            readdata         <= {DATA_WIDTH{1'b0}};
            response         <= 2'b00;
            readresponseuser <= {USER_WIDTH{1'b0}};
            rd_addr_r        <= {DEPTH_LOG2{1'b0}};
            rd_left_r        <= CNT_ZERO;
            wr_addr_r        <= {DEPTH_LOG2{1'b0}};
            wr_left_r        <= CNT_ZERO;
        end else begin
            readdatavalid <= 1'b0;
            response      <= 2'b00;
            case (state_r)
                IDLE: begin
                    wait_r <= 1'b0;
                    if (wr_sop_s) begin
                        if (cnt_s != CNT_ONE) begin
                            state_r   <= WR_BURST;
                            wr_addr_r <= base_s + ADDR_ONE;
                            wr_left_r <= cnt_s - CNT_ONE;
                        end
                    end else if (rd_sop_s) begin
                        state_r          <= RD_BURST;
                        wait_r           <= 1'b1;
                        readdatavalid    <= 1'b1;
                        readdata         <= mem[base_s];
                        readresponseuser <= user;
                        rd_addr_r        <= base_s + ADDR_ONE;
                        rd_left_r        <= cnt_s - CNT_ONE;
                    end
                end
                WR_BURST: begin
                    if (write) begin
                        wr_addr_r <= wr_addr_r + ADDR_ONE;
                        wr_left_r <= wr_left_r - CNT_ONE;
                        if (wr_left_r == CNT_ONE) begin
                            state_r <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    if (rd_left_r != CNT_ZERO) begin
                        readdatavalid <= 1'b1;
                        readdata      <= mem[rd_addr_r];
                        rd_addr_r     <= rd_addr_r + ADDR_ONE;
                        rd_left_r     <= rd_left_r - CNT_ONE;
                    end else begin
                        state_r <= IDLE;
                        wait_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    wait_r  <= 1'b1;
                end
            endcase
        end
    end

`ifdef OFS_PLAT_AVALON_MEM_RSP_RAM_WRRSP_EN
    logic [USER_WIDTH-1:0] wr_user_r;

    // Write response: pulse one cycle after the final beat, carrying the SOP user.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_user_r          <= {USER_WIDTH{1'b0}};
            writeresponsevalid <= 1'b0;
            writeresponse      <= 2'b00;
            writeresponseuser  <= {USER_WIDTH{1'b0}};
        end else begin
            writeresponsevalid <= wr_last_s;
            writeresponse      <= 2'b00;
            if (wr_sop_s) begin
                wr_user_r <= user;
            end
            if (wr_last_s) begin
                writeresponseuser <= wr_sop_s ? user : wr_user_r;
            end
        end
    end
`else
    assign writeresponsevalid = 1'b0;
    assign writeresponse      = 2'b00;
    assign writeresponseuser  = {USER_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rsp_ram.sv
// Directed self-checking bench for ofs_plat_avalon_mem_rsp_ram (default parameters).
module tb_ofs_plat_avalon_mem_rsp_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  burstcount;
    logic [63:0] writedata;
    logic [7:0]  byteenable;
    logic [0:0]  user;
    logic        waitrequest;
    logic        readdatavalid;
    logic [63:0] readdata;
    logic [1:0]  response;
    logic [0:0]  readresponseuser;
    logic        writeresponsevalid;
    logic [1:0]  writeresponse;
    logic [0:0]  writeresponseuser;

    int tests = 0;
    int fails = 0;

    ofs_plat_avalon_mem_rsp_ram dut (
        .clk                (clk),
        .reset              (reset),
        .address            (address),
        .read               (read),
        .write              (write),
        .burstcount         (burstcount),
        .writedata          (writedata),
        .byteenable         (byteenable),
        .user               (user),
        .waitrequest        (waitrequest),
        .readdatavalid      (readdatavalid),
        .readdata           (readdata),
        .response           (response),
        .readresponseuser   (readresponseuser),
        .writeresponsevalid (writeresponsevalid),
        .writeresponse      (writeresponse),
        .writeresponseuser  (writeresponseuser)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_burst(input logic [31:0] a, input int bc, input int n,
                            input logic [63:0] d, input logic [7:0] be, input logic u);
        for (int i = 0; i < n; i++) begin
            address    = a;
            write      = 1'b1;
            burstcount = bc[3:0];
            writedata  = d + 64'(i);
            byteenable = be;
            user       = u;
            chk("wr_wait", {63'd0, waitrequest}, 64'd0);
            tick();
        end
        write = 1'b0;
`ifdef OFS_PLAT_AVALON_MEM_RSP_RAM_WRRSP_EN
        chk("wrrsp_valid", {63'd0, writeresponsevalid}, 64'd1);
        chk("wrrsp_user", {63'd0, writeresponseuser}, {63'd0, u});
        chk("wrrsp_code", {62'd0, writeresponse}, 64'd0);
`else
        chk("wrrsp_off", {63'd0, writeresponsevalid}, 64'd0);
`endif
        tick();
        chk("wrrsp_pulse", {63'd0, writeresponsevalid}, 64'd0);
    endtask

    task automatic rd_burst(input logic [31:0] a, input int bc, input int n,
                            input logic u, input logic [63:0] exp);
        address    = a;
        read       = 1'b1;
        burstcount = bc[3:0];
        user       = u;
        chk("rd_accept_wait", {63'd0, waitrequest}, 64'd0);
        tick();
        read = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk("rd_valid", {63'd0, readdatavalid}, 64'd1);
            chk("rd_data", readdata, exp + 64'(i));
            chk("rd_resp", {62'd0, response}, 64'd0);
            chk("rd_user", {63'd0, readresponseuser}, {63'd0, u});
            chk("rd_busy_wait", {63'd0, waitrequest}, 64'd1);
            tick();
        end
        chk("rd_end_valid", {63'd0, readdatavalid}, 64'd0);
        chk("rd_end_wait", {63'd0, waitrequest}, 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        address    = 32'd0;
        read       = 1'b0;
        write      = 1'b0;
        burstcount = 4'd1;
        writedata  = 64'd0;
        byteenable = 8'hFF;
        user       = 1'b0;
        tick(); tick(); tick();

        // Reset state
        chk("rst_wait", {63'd0, waitrequest}, 64'd1);
        chk("rst_rdv", {63'd0, readdatavalid}, 64'd0);
        chk("rst_rdata", readdata, 64'd0);
        chk("rst_wrv", {63'd0, writeresponsevalid}, 64'd0);
        chk("rst_ruser", {63'd0, readresponseuser}, 64'd0);
        reset = 1'b0;
        chk("post_rst1_wait", {63'd0, waitrequest}, 64'd1);
        tick();
        chk("post_rst2_wait", {63'd0, waitrequest}, 64'd0);

        // Burst write/read 0x10
        wr_burst(32'h10, 4, 4, 64'hA, 8'hFF, 1'b0);
        rd_burst(32'h10, 4, 4, 1'b0, 64'hA);

        // Byte enables
        wr_burst(32'h05, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        wr_burst(32'h05, 1, 1, 64'h0, 8'h0F, 1'b0);
        rd_burst(32'h05, 1, 1, 1'b0, 64'hFFFF_FFFF_0000_0000);

        // Address wrap at top of storage
        wr_burst(32'hFE, 3, 3, 64'h100, 8'hFF, 1'b1);
        rd_burst(32'hFE, 3, 3, 1'b0, 64'h100);
        rd_burst(32'h00, 1, 1, 1'b0, 64'h102);

        // Read burst 2 with user=1
        rd_burst(32'h10, 2, 2, 1'b1, 64'hA);

        // burstcount 0 behaves as 1
        wr_burst(32'h30, 0, 1, 64'h77, 8'hFF, 1'b1);
        chk("bc0_idle_wait", {63'd0, waitrequest}, 64'd0);
        rd_burst(32'h30, 0, 1, 1'b1, 64'h77);

        // read+write together: write wins, read dropped
        address    = 32'h20;
        read       = 1'b1;
        write      = 1'b1;
        burstcount = 4'd1;
        writedata  = 64'h55;
        byteenable = 8'hFF;
        tick();
        read  = 1'b0;
        write = 1'b0;
        chk("rw_no_rdv", {63'd0, readdatavalid}, 64'd0);
        chk("rw_wait", {63'd0, waitrequest}, 64'd0);
        tick();
        rd_burst(32'h20, 1, 1, 1'b0, 64'h55);

        // Reset during beat 2 of a read burst of 8
        wr_burst(32'h40, 8, 8, 64'h200, 8'hFF, 1'b0);
        address    = 32'h40;
        read       = 1'b1;
        burstcount = 4'd8;
        user       = 1'b0;
        tick();
        read = 1'b0;
        chk("abort_beat1", readdata, 64'h200);
        tick();
        chk("abort_beat2", readdata, 64'h201);
        chk("abort_beat2_v", {63'd0, readdatavalid}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_rdv0", {63'd0, readdatavalid}, 64'd0);
        chk("abort_wait", {63'd0, waitrequest}, 64'd1);
        chk("abort_rdata", readdata, 64'd0);
        tick();
        chk("abort_rdv1", {63'd0, readdatavalid}, 64'd0);
        chk("abort_wait_open", {63'd0, waitrequest}, 64'd0);
        tick();
        chk("abort_rdv2", {63'd0, readdatavalid}, 64'd0);
        rd_burst(32'h40, 8, 8, 1'b0, 64'h200);

        // Write burst 2 with user=1 (write response when enabled)
        wr_burst(32'h60, 2, 2, 64'h300, 8'hFF, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ofs_plat_avalon_mem_rsp_ram.md
OFS_PLAT_AVALON_MEM_RSP_RAM -- requirements
Module: ofs_plat_avalon_mem_rsp_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, word address width of the request port.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data bus width in bits; byte lanes = DATA_WIDTH/8.
REQ-003 SHALL have parameter BURST_CNT_WIDTH, default 4, burstcount width.
REQ-004 SHALL have parameter USER_WIDTH, default 1, width of user, readresponseuser and writeresponseuser.
REQ-005 SHALL have parameter DEPTH_LOG2, default 8, log2 of storage depth in words.
REQ-006 SHALL have port clk input 1, the single clock; all logic on posedge.
REQ-007 SHALL have port reset input 1, synchronous, active-high.
REQ-008 SHALL have request inputs: address ADDR_WIDTH, read 1, write 1, burstcount BURST_CNT_WIDTH, writedata DATA_WIDTH, byteenable DATA_WIDTH/8, user USER_WIDTH.
REQ-009 SHALL have output waitrequest 1, request stall.
REQ-010 SHALL have read outputs: readdatavalid 1, readdata DATA_WIDTH, response 2, readresponseuser USER_WIDTH.
REQ-011 SHALL have write-response outputs: writeresponsevalid 1, writeresponse 2, writeresponseuser USER_WIDTH.

Function
REQ-012 SHALL act as an Avalon-MM responder with zero waitrequest allowance: a request transfers only in a cycle with waitrequest=0.
REQ-013 SHALL implement FSM states IDLE, WR_BURST, RD_BURST; only IDLE accepts read or write SOP.
REQ-014 SHALL index storage with address[DEPTH_LOG2-1:0]; beat i of a burst uses (base+i) mod 2^DEPTH_LOG2 (wraps at top).
REQ-015 SHALL treat burstcount=0 as burstcount=1.
REQ-016 Write SOP accepted in IDLE: write beat to base, bytes gated by byteenable; burstcount>1 -> WR_BURST, else stay IDLE.
REQ-017 WR_BURST: waitrequest=0; each accepted beat writes next address; burstcount/address on non-SOP beats ignored; last beat -> IDLE.
REQ-018 Read accepted in cycle N (IDLE): latch base, count, user; enter RD_BURST; readdatavalid=1 in cycles N+1 .. N+count, one beat per cycle, no gaps.
REQ-019 waitrequest SHALL be 1 from cycle N+1 through last read beat; 0 again in the cycle after last beat.
REQ-020 Read beats SHALL return response=2'b00 and readresponseuser=latched user on every beat.
REQ-021 readdata SHALL reflect memory contents including writes completed in earlier cycles (no stale-data hazard).
REQ-022 read and write both asserted in IDLE: write SHALL be accepted, read dropped.
REQ-023 read asserted in WR_BURST SHALL be ignored (accepted as no-op); bench treats it as protocol violation.
REQ-024 Burst counters SHALL be BURST_CNT_WIDTH bits; max burst 2^BURST_CNT_WIDTH-1.

Reset
REQ-025 While reset=1 and the first cycle after: FSM=IDLE, waitrequest=1, readdatavalid=0, writeresponsevalid=0, readdata/response/readresponseuser/writeresponse/writeresponseuser=0.
REQ-026 waitrequest SHALL drop to 0 the second cycle after reset deasserts.
REQ-027 Reset mid-burst SHALL abort the burst with no further beats or responses; memory contents SHALL NOT be cleared.

Configuration
REQ-028 Macro OFS_PLAT_AVALON_MEM_RSP_RAM_WRRSP_EN defined: writeresponsevalid pulses 1 cycle after the last write beat is accepted, writeresponse=2'b00, writeresponseuser=user latched at SOP; may coincide with readdatavalid.
REQ-029 Macro undefined: writeresponsevalid, writeresponse, writeresponseuser tied to 0; no response state logic.

Verification
REQ-030 Write addr 0x10 burst 4 data 0xA..0xD, byteenable 0xFF, then read addr 0x10 burst 4 -> readdatavalid 4 consecutive cycles, readdata 0xA,0xB,0xC,0xD, response 0.
REQ-031 Write addr 0x05 data 0xFFFF_FFFF_FFFF_FFFF, then write addr 0x05 data 0 byteenable 0x0F, read 0x05 -> 0xFFFF_FFFF_0000_0000.
REQ-032 DEPTH_LOG2=8: write burst 3 at 0xFE -> words 0xFE,0xFF,0x00 updated; read burst 3 at 0xFE returns same.
REQ-033 Read burst 2 user=1 accepted at cycle N -> waitrequest=1 cycles N+1..N+2, readresponseuser=1 both beats, waitrequest=0 cycle N+3.
REQ-034 reset pulsed during read beat 2 of burst 8 -> no readdatavalid after reset edge; subsequent read returns pre-reset contents.
REQ-035 WRRSP_EN defined: write burst 2 user=1 last beat cycle M -> writeresponsevalid=1 only in M+1, writeresponseuser=1; undefined -> writeresponsevalid stays 0.
